rr_arb_ctrl: RTL and testbench

RR_ARB_CTRL -- requirements
Module: rr_arb_ctrl

---
 rtl/rr_arb_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rr_arb_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter with registered one-hot grant and a rotating priority pointer.
// Optional burst lock (repeat grant to a locked requester) is enabled by defining ARB_LOCK_EN.
module rr_arb_ctrl #(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       ack_i,
    input  logic [NUM_REQ-1:0]         lock_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       gnt_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic [$clog2(NUM_REQ)-1:0] ptr_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [IDX_W:0]     pick_open;
    logic [IDX_W:0]     pick_ack;
    logic [IDX_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] req_masked;

`ifdef ARB_LOCK_EN
    localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic               lock_hold;
`else
    logic               unused_lock;
    assign unused_lock = ^lock_i;
`endif

    // Returns {valid, index}: lowest set bit at or above ptr, else lowest set bit overall.
    function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IDX_W-1:0]   ptr);
        logic             hi_v, lo_v;
        logic [IDX_W-1:0] hi_i, lo_i;
        hi_v = 1'b0;
        lo_v = 1'b0;
        hi_i = '0;
        lo_i = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req[i-1]) begin
                lo_v = 1'b1;
                lo_i = IDX_W'(i - 1);
                if ((i - 1) >= 32'(ptr)) begin
                    hi_v = 1'b1;
                    hi_i = IDX_W'(i - 1);
                end
            end
        end
        if (hi_v) begin
            return {1'b1, hi_i};
        end
        return {lo_v, lo_i};
    endfunction

    always_comb begin
        ptr_next   = idx_q + 1'b1;
        req_masked = req_i & ~(NUM_REQ'(1) << idx_q);
        pick_open  = pick(req_i, ptr_q);
        pick_ack   = pick(req_masked, ptr_next);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
        lock_hold  = lock_i[idx_q] && (lock_cnt_q < LOCK_W'(MAX_LOCK - 1));
`endif
        unique case (state_q)
            IDLE: begin
                if (en_i && pick_open[IDX_W]) begin
                    state_d = GRANT;
                    idx_d   = pick_open[IDX_W-1:0];
                    gnt_d   = NUM_REQ'(1) << pick_open[IDX_W-1:0];
                end else begin
                    gnt_d = '0;
                    idx_d = '0;
                end
            end
            GRANT: begin
                if (ack_i) begin
`ifdef ARB_LOCK_EN
                    if (lock_hold) begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end else begin
                        lock_cnt_d = '0;
`else
                    begin
`endif
                        ptr_d = ptr_next;
                        if (en_i && pick_ack[IDX_W]) begin
                            idx_d = pick_ack[IDX_W-1:0];
                            gnt_d = NUM_REQ'(1) << pick_ack[IDX_W-1:0];
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                            gnt_d   = '0;
                        end
                    end
                end else if (!req_i[idx_q]) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    gnt_d   = '0;
`ifdef ARB_LOCK_EN
                    lock_cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                gnt_d   = '0;
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            idx_q       <= '0;
            ptr_q       <= '0;
`ifdef ARB_LOCK_EN
            lock_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
`ifdef ARB_LOCK_EN
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gnt_valid_q;
    assign gnt_idx_o   = idx_q;
    assign ptr_o       = ptr_q;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Directed self-checking bench for rr_arb_ctrl (NUM_REQ=8, MAX_LOCK=4).
// Lock-sequence expectations follow whether ARB_LOCK_EN is defined.
module tb_rr_arb_ctrl;

    logic       clk;
    logic       rst;
    logic       en_i;
    logic [7:0] req_i;
    logic       ack_i;
    logic [7:0] lock_i;
    logic [7:0] gnt_o;
    logic       gnt_valid_o;
    logic [2:0] gnt_idx_o;
    logic [2:0] ptr_o;

    int unsigned n_checks;
    int unsigned n_errors;

    rr_arb_ctrl #(.NUM_REQ(8), .MAX_LOCK(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .req_i       (req_i),
        .ack_i       (ack_i),
        .lock_i      (lock_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_idx_o   (gnt_idx_o),
        .ptr_o       (ptr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, and check the grant invariants.
    task automatic step;
        @(posedge clk);
        #1;
        check_eq("onehot0", 32'($onehot0(gnt_o)), 32'd1);
        check_eq("valid_or", 32'(gnt_valid_o), 32'(|gnt_o));
    endtask

    task automatic expect_state(input string tag, input logic [7:0] g, input logic [2:0] p);
        logic [2:0] gi;
        gi = '0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) gi = 3'(i);
        end
        check_eq({tag, ".gnt"}, 32'(gnt_o), 32'(g));
        check_eq({tag, ".idx"}, 32'(gnt_idx_o), 32'(gi));
        check_eq({tag, ".ptr"}, 32'(ptr_o), 32'(p));
    endtask

    logic [7:0] lk_gnt [5];
    logic [2:0] lk_ptr [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        en_i   = 1'b0;
        req_i  = '0;
        ack_i  = 1'b0;
        lock_i = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_state("reset", 8'h00, 3'd0);
        check_eq("reset.valid", 32'(gnt_valid_o), 32'd0);

        // Alternating grants between 0 and 7 with continuous ack
        rst   = 1'b0;
        en_i  = 1'b1;
        req_i = 8'h81;
        ack_i = 1'b1;
        step(); expect_state("alt0", 8'h01, 3'd0);
        step(); expect_state("alt1", 8'h80, 3'd1);
        step(); expect_state("alt2", 8'h01, 3'd0);
        step(); expect_state("alt3", 8'h80, 3'd1);

        // Steer pointer to 7, then check the wrap to 0
        req_i = 8'h40;
        step(); expect_state("to6", 8'h40, 3'd0);
        req_i = 8'hC1;
        step(); expect_state("ptr7", 8'h80, 3'd7);
        step(); expect_state("wrap", 8'h01, 3'd0);

        // Ack with no remaining requester -> IDLE; ack in IDLE ignored
        req_i = 8'h00;
        step(); expect_state("drain", 8'h00, 3'd1);
        step(); expect_state("idle_ack", 8'h00, 3'd1);

        // en_i low in IDLE blocks new grants
        en_i  = 1'b0;
        ack_i = 1'b0;
        req_i = 8'h04;
        step(); expect_state("en_off", 8'h00, 3'd1);
        en_i = 1'b1;
        step(); expect_state("g4", 8'h04, 3'd1);

        // Held grant ignores en_i and other requesters
        req_i = 8'h05;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) en_i = 1'b0;
            step(); expect_state("hold", 8'h04, 3'd1);
        end
        ack_i = 1'b1;
        step(); expect_state("ack4", 8'h00, 3'd3);

        // Withdrawal without ack
        ack_i = 1'b0;
        en_i  = 1'b1;
        req_i = 8'h10;
        step(); expect_state("g10", 8'h10, 3'd3);
        req_i = 8'h00;
        step(); expect_state("withdraw", 8'h00, 3'd3);

        // Burst lock sequence from ptr 3
`ifdef ARB_LOCK_EN
        lk_gnt = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h01};
        lk_ptr = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
`else
        lk_gnt = '{8'h08, 8'h01, 8'h08, 8'h01, 8'h08};
        lk_ptr = '{3'd3, 3'd4, 3'd1, 3'd4, 3'd1};
`endif
        req_i  = 8'h09;
        lock_i = 8'h08;
        ack_i  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(); expect_state("lock", lk_gnt[c], lk_ptr[c]);
        end

        // Asynchronous reset in the middle of a grant
        check_eq("pre_rst.valid", 32'(gnt_valid_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        expect_state("async_rst", 8'h00, 3'd0);
        check_eq("async_rst.valid", 32'(gnt_valid_o), 32'd0);

        // First edge after release arbitrates
        lock_i = 8'h00;
        ack_i  = 1'b0;
        req_i  = 8'h02;
        en_i   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(); expect_state("post_rst", 8'h02, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
